f1_input_driver: RTL and testbench

- Producer end of the F1 program-input interface of the pipelined core's register file.
- Drives `t0`, the start trigger, into register x5 and `t4`, the random delay value, into register x29.
- Conditions a raw asynchronous push-button: 2-FF synchroniser, debouncer, one-shot trigger FSM with a hold window so the polling program cannot miss it.
- Captures a free-running LFSR value into `t4` at trigger time.

---
 rtl/f1_input_driver.sv | 171 +++++++++++++++++
 tb/tb_f1_input_driver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/f1_input_driver.sv
// F1 program-input producer: conditions a raw push-button into a one-shot t0 pulse
// and captures a free-running LFSR into t4. Optional macro: F1_MANUAL_SEED_EN.
module f1_input_driver #(
    parameter int                    DATAWIDTH       = 32,
    parameter int                    LFSR_WIDTH      = 7,
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS       = 7'h60,
    parameter int                    DEBOUNCE_CYCLES = 4,
    parameter int                    HOLD_CYCLES     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn_in,
`ifdef F1_MANUAL_SEED_EN
    input  logic                  seed_load,
    input  logic [LFSR_WIDTH-1:0] seed_in,
`endif
    output logic                  t0,
    output logic [DATAWIDTH-1:0]  t4,
    output logic                  busy
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    localparam logic [LFSR_WIDTH-1:0] LFSR_ONE = LFSR_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_RELEASE
    } state_t;

    logic s1;
    logic s2;

    logic           btn_db;
    logic           btn_db_q;
    logic           btn_db_next;
    logic [DBW-1:0] db_cnt;
    logic [DBW-1:0] db_cnt_next;

    logic [LFSR_WIDTH-1:0] lfsr;
    logic [LFSR_WIDTH-1:0] lfsr_adv;
    logic [LFSR_WIDTH-1:0] lfsr_next;
    logic                  fb;

    state_t         state;
    state_t         state_next;
    logic [HCW-1:0] hold_cnt;
    logic [HCW-1:0] hold_next;
    logic           t0_next;
    logic [DATAWIDTH-1:0] t4_next;
    logic           rise;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    always_comb begin
        db_cnt_next = '0;
        btn_db_next = btn_db;
        if (s2 != btn_db) begin
            if (db_cnt == DB_LAST) begin
                btn_db_next = s2;
            end else begin
                db_cnt_next = db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            db_cnt   <= db_cnt_next;
            btn_db   <= btn_db_next;
            btn_db_q <= btn_db;
        end
    end

    assign fb       = ^(lfsr & LFSR_TAPS);
    assign lfsr_adv = (lfsr == '0) ? LFSR_ONE
                                   : {lfsr[LFSR_WIDTH-2:0], fb};

`ifdef F1_MANUAL_SEED_EN
    always_comb begin
        lfsr_next = lfsr_adv;
        if (seed_load) begin
            lfsr_next = (seed_in == '0) ? LFSR_ONE : seed_in;
        end
    end
`else
    assign lfsr_next = lfsr_adv;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_ONE;
        end else begin
            lfsr <= lfsr_next;
        end
    end

    assign rise = btn_db & ~btn_db_q;

    // Trigger FSM; t0 and t4 are registered so the register file sees clean levels.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        t0_next    = t0;
        t4_next    = t4;
        unique case (state)
            IDLE: begin
                t0_next = 1'b0;
                if (rise) begin
                    state_next = HOLD;
                    t0_next    = 1'b1;
                    t4_next    = DATAWIDTH'(lfsr);
                    hold_next  = HOLD_LAST;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_next = WAIT_RELEASE;
                    t0_next    = 1'b0;
                end else begin
                    hold_next = hold_cnt - 1'b1;
                end
            end
            WAIT_RELEASE: begin
                t0_next = 1'b0;
                if (!btn_db) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                t0_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            t0       <= 1'b0;
            t4       <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            t0       <= t0_next;
            t4       <= t4_next;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_f1_input_driver.sv
// Directed and randomized checks of f1_input_driver against a timing/LFSR model.
module tb_f1_input_driver;

    localparam int DB   = 4;
    localparam int HOLD = 16;

    logic        clk;
    logic        rst_n;
    logic        btn_in;
    logic        t0;
    logic [31:0] t4;
    logic        busy;
`ifdef F1_MANUAL_SEED_EN
    logic        seed_load;
    logic [6:0]  seed_in;
`endif

    int errors = 0;
    int checks = 0;
    int n = 0;

    logic [6:0] seq [0:2047];

    f1_input_driver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
`ifdef F1_MANUAL_SEED_EN
        .seed_load (seed_load),
        .seed_in   (seed_in),
`endif
        .t0        (t0),
        .t4        (t4),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        btn_in = 1'b0;
        #1;
        chk("rst_t0", {31'b0, t0}, 32'h0);
        chk("rst_t4", t4, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_lfsr", {25'b0, dut.lfsr}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
    endtask

    initial begin
        logic [6:0]  t1_exp [7];
        logic [31:0] exp_t4;
        int          hi_cnt;
        int          p, h, r, trig, e_end, extra, v;

        rst_n  = 1'b1;
        btn_in = 1'b0;
`ifdef F1_MANUAL_SEED_EN
        seed_load = 1'b0;
        seed_in   = '0;
`endif
        // LFSR sequence from x^7+x^6+1: shift left, feed back bit6 xor bit5.
        seq[0] = 7'd1;
        for (int k = 1; k < 2048; k++) begin
            v = int'(seq[k-1]);
            seq[k] = 7'((v * 2 + ((v / 64) + (v / 32) % 2) % 2) % 128);
        end
        t1_exp = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};

        #2;
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("idle_lfsr", {25'b0, dut.lfsr}, {25'b0, t1_exp[i-1]});
            chk("idle_t0", {31'b0, t0}, 32'h0);
            chk("idle_t4", t4, 32'h0);
            chk("idle_busy", {31'b0, busy}, 32'h0);
        end

        // Held press, released before edge 31.
        do_reset();
        btn_in = 1'b1;
        for (int e = 1; e <= 45; e++) begin
            if (e == 31) btn_in = 1'b0;
            tick();
            chk("press_t0", {31'b0, t0}, {31'b0, (e >= 7 && e <= 22)});
            chk("press_busy", {31'b0, busy}, {31'b0, (e >= 7 && e <= 36)});
            chk("press_t4", t4, (e >= 7) ? 32'h41 : 32'h0);
        end

        // Bounce: 2 high, 1 low, three times.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            btn_in = (i < 9) && (i % 3 != 2);
            tick();
            chk("bounce_db", {31'b0, dut.btn_db}, 32'h0);
            chk("bounce_t0", {31'b0, t0}, 32'h0);
            chk("bounce_busy", {31'b0, busy}, 32'h0);
        end

        // Re-press during HOLD must not retrigger.
        do_reset();
        btn_in = 1'b1;
        hi_cnt = 0;
        for (int e = 1; e <= 50; e++) begin
            if (e == 11) btn_in = 1'b0;
            if (e == 17) btn_in = 1'b1;
            if (e == 40) btn_in = 1'b0;
            tick();
            if (t0) hi_cnt++;
            chk("repress_t4", t4, (e >= 7) ? 32'h41 : 32'h0);
            chk("repress_busy", {31'b0, busy}, {31'b0, (e >= 7 && e <= 45)});
        end
        chk("repress_hi_cnt", hi_cnt, HOLD);

        // Asynchronous reset in the middle of HOLD.
        do_reset();
        btn_in = 1'b1;
        for (int e = 1; e <= 12; e++) tick();
        chk("midhold_t0", {31'b0, t0}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_t0", {31'b0, t0}, 32'h0);
        chk("async_t4", t4, 32'h0);
        chk("async_busy", {31'b0, busy}, 32'h0);
        btn_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        btn_in = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("after_rst_t0", {31'b0, t0}, {31'b0, (e >= 7)});
            chk("after_rst_t4", t4, (e >= 7) ? 32'h41 : 32'h0);
        end
        btn_in = 1'b0;

        // Randomized press lengths and gaps against the timing model.
        do_reset();
        exp_t4 = 32'h0;
        repeat (8) begin
            h     = $urandom_range(DB, 40);
            extra = $urandom_range(0, 8);
            p     = n;
            trig  = p + 3 + DB;
            r     = p + h;
            e_end = (trig + HOLD + 1 > r + 3 + DB) ? trig + HOLD + 1 : r + 3 + DB;
            btn_in = 1'b1;
            while (n < e_end + extra && n < 2000) begin
                if (n == r) btn_in = 1'b0;
                tick();
                if (n == trig) exp_t4 = {25'b0, seq[trig-1]};
                chk("rand_t0", {31'b0, t0}, {31'b0, (n >= trig && n < trig + HOLD)});
                chk("rand_busy", {31'b0, busy}, {31'b0, (n >= trig && n < e_end)});
                chk("rand_t4", t4, exp_t4);
            end
        end

`ifdef F1_MANUAL_SEED_EN
        do_reset();
        seed_load = 1'b1;
        seed_in   = 7'h00;
        tick();
        chk("seed0_lfsr", {25'b0, dut.lfsr}, 32'h01);
        seed_load = 1'b0;
        tick();
        chk("seed0_next", {25'b0, dut.lfsr}, 32'h02);
        tick();
        chk("seed0_next2", {25'b0, dut.lfsr}, 32'h04);
        seed_load = 1'b1;
        seed_in   = 7'h55;
        tick();
        chk("seed55_lfsr", {25'b0, dut.lfsr}, 32'h55);
        seed_load = 1'b0;
        tick();
        chk("seed55_next", {25'b0, dut.lfsr}, 32'h2B);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
